// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID pipeline register built as a DEPTH-entry skid FIFO with a valid/ready
// handshake, decoded head-entry fields, bubble on empty/flush and a saturating backpressure counter.
module ifid_skid_stage #(
    parameter int          PC_WIDTH    = 32,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] BUBBLE_INST = 32'h00000000,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [PC_WIDTH-1:0]  PCAddResult,
    input  logic [31:0]          Instruction,
    input  logic                 Flush,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [PC_WIDTH-1:0]  IDPCAddResult,
    output logic [31:0]          IDInst,
    output logic [5:0]           Opcode,
    output logic [4:0]           RR1In,
    output logic [4:0]           RR2In,
    output logic [4:0]           ID1511Inst,
    output logic [4:0]           ID106Inst,
    output logic [5:0]           Funct,
    output logic [15:0]          SignExIn,
    output logic [25:0]          ID250Inst,
    output logic [CNT_WIDTH-1:0] StallCount
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("ifid_skid_stage: DEPTH must be in 1..8");
    end

    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [31:0]          inst_mem [DEPTH];
    logic                 push, pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign InReady  = cnt_q < CW'(DEPTH);
    assign OutValid = cnt_q != '0;
    assign push     = InValid && InReady && !Flush;
    assign pop      = OutValid && OutReady && !Flush;

    always_comb begin
        wr_d    = Flush ? '0 : push ? ptr_inc(wr_q) : wr_q;
        rd_d    = Flush ? '0 : pop ? ptr_inc(rd_q) : rd_q;
        cnt_d   = Flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        stall_d = (OutValid && !OutReady && !Flush && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Payload storage needs no reset: it is masked by OutValid.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_q]   <= PCAddResult;
            inst_mem[wr_q] <= Instruction;
        end
    end

    assign IDInst        = OutValid ? inst_mem[rd_q] : BUBBLE_INST;
    assign IDPCAddResult = OutValid ? pc_mem[rd_q] : '0;
    assign Opcode        = IDInst[31:26];
    assign RR1In         = IDInst[25:21];
    assign RR2In         = IDInst[20:16];
    assign ID1511Inst    = IDInst[15:11];
    assign ID106Inst     = IDInst[10:6];
    assign Funct         = IDInst[5:0];
    assign SignExIn      = IDInst[15:0];
    assign ID250Inst     = IDInst[25:0];
    assign StallCount    = stall_q;
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: three ifid_skid_stage variants (DEPTH 2/3/1) on shared stimulus,
// checked against queue-based reference models plus a directed vector table.
module tb_ifid_skid_stage;
    logic        Clk, Reset, InValid, Flush, OutReady;
    logic [31:0] PCAddResult, Instruction;
    int          n_vec = 0, n_err = 0;
    bit          chk_en = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    initial Clk = 0;
    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam int CW = (g == 2) ? 4 : 16;
        logic          ov, ir;
        logic [31:0]   pc, inst;
        logic [5:0]    op, fn;
        logic [4:0]    rs, rt, rd, sh;
        logic [15:0]   imm;
        logic [25:0]   tgt;
        logic [CW-1:0] sc;
        logic [63:0]   q[$];
        int unsigned   stall = 0;

        ifid_skid_stage #(.DEPTH(D), .CNT_WIDTH(CW)) dut (
            .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir),
            .PCAddResult(PCAddResult), .Instruction(Instruction), .Flush(Flush),
            .OutValid(ov), .OutReady(OutReady), .IDPCAddResult(pc), .IDInst(inst),
            .Opcode(op), .RR1In(rs), .RR2In(rt), .ID1511Inst(rd), .ID106Inst(sh),
            .Funct(fn), .SignExIn(imm), .ID250Inst(tgt), .StallCount(sc)
        );

        // Reference: a bounded queue; flush empties it, stalls count up to all-ones.
        always @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                q.delete();
                stall = 0;
            end else begin
                automatic bit has  = q.size() != 0;
                automatic bit room = q.size() < D;
                if (Flush) q.delete();
                else begin
                    if (has && OutReady) void'(q.pop_front());
                    if (InValid && room) q.push_back({PCAddResult, Instruction});
                end
                if (has && !OutReady && !Flush && stall < 2 ** CW - 1) stall++;
            end
        end

        always @(negedge Clk) begin
            if (chk_en) begin
                automatic logic [31:0] ei = (q.size() != 0) ? q[0][31:0] : 32'h0;
                automatic logic [31:0] ep = (q.size() != 0) ? q[0][63:32] : 32'h0;
                check($sformatf("m%0d.OutValid", g), 64'(ov), 64'(q.size() != 0));
                check($sformatf("m%0d.InReady", g), 64'(ir), 64'(q.size() < D));
                check($sformatf("m%0d.IDInst", g), 64'(inst), 64'(ei));
                check($sformatf("m%0d.IDPC", g), 64'(pc), 64'(ep));
                check($sformatf("m%0d.fields", g), {op, rs, rt, rd, sh, fn, imm, tgt},
                      {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[10:6], ei[5:0], ei[15:0], ei[25:0]});
                check($sformatf("m%0d.StallCount", g), 64'(sc), 64'(stall));
            end
        end
    end

    typedef struct {
        logic        inv, flush, ordy;
        logic [31:0] pc, inst;
        logic        ov, ir;
        logic [31:0] e_inst, e_pc;
        int          e_stall;
    } vec_t;
    vec_t tbl[13];

    task automatic drive(input logic inv, input logic fl, input logic ordy, input logic [31:0] p, input logic [31:0] i);
        InValid = inv; Flush = fl; OutReady = ordy; PCAddResult = p; Instruction = i;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] LW = 32'h8C220004, A = 32'h20010001, B = 32'h20020002, C = 32'h20030003;

    initial begin
        tbl[0]  = '{1, 0, 1, 32'h4,  LW, 1, 1, LW, 32'h4,  0};
        tbl[1]  = '{0, 0, 1, 32'h0,  0,  0, 1, 0,  32'h0,  0};
        tbl[2]  = '{1, 0, 0, 32'h8,  A,  1, 1, A,  32'h8,  0};
        tbl[3]  = '{1, 0, 0, 32'hC,  B,  1, 0, A,  32'h8,  1};
        tbl[4]  = '{1, 0, 0, 32'h10, C,  1, 0, A,  32'h8,  2};
        tbl[5]  = '{1, 0, 0, 32'h10, C,  1, 0, A,  32'h8,  3};
        tbl[6]  = '{1, 0, 1, 32'h10, C,  1, 1, B,  32'hC,  3};
        tbl[7]  = '{1, 0, 1, 32'h10, C,  1, 1, C,  32'h10, 3};
        tbl[8]  = '{0, 0, 1, 32'h0,  0,  0, 1, 0,  32'h0,  3};
        tbl[9]  = '{1, 0, 0, 32'h8,  A,  1, 1, A,  32'h8,  3};
        tbl[10] = '{1, 0, 0, 32'hC,  B,  1, 0, A,  32'h8,  4};
        tbl[11] = '{1, 1, 0, 32'h10, C,  0, 1, 0,  32'h0,  4};
        tbl[12] = '{0, 0, 0, 32'h0,  0,  0, 1, 0,  32'h0,  4};

        drive(0, 0, 0, 0, 0);
        Reset = 1;
        #1 Reset = 0;
        chk_en = 1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1;

        // Directed table against the DEPTH=2 instance.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].inv, tbl[i].flush, tbl[i].ordy, tbl[i].pc, tbl[i].inst);
            tick();
            check($sformatf("tbl%0d.OutValid", i), 64'(u[0].ov), 64'(tbl[i].ov));
            check($sformatf("tbl%0d.InReady", i), 64'(u[0].ir), 64'(tbl[i].ir));
            check($sformatf("tbl%0d.IDInst", i), 64'(u[0].inst), 64'(tbl[i].e_inst));
            check($sformatf("tbl%0d.IDPC", i), 64'(u[0].pc), 64'(tbl[i].e_pc));
            check($sformatf("tbl%0d.Opcode", i), 64'(u[0].op), 64'(tbl[i].e_inst[31:26]));
            check($sformatf("tbl%0d.StallCount", i), 64'(u[0].sc), 64'(tbl[i].e_stall));
            if (i == 0)
                check("lw.decode", {u[0].op, u[0].rs, u[0].rt, u[0].imm}, {6'h23, 5'd1, 5'd2, 16'h0004});
        end

        // Asynchronous reset with two entries held, observed before any edge.
        drive(1, 0, 0, 32'h8, A);
        tick();
        drive(1, 0, 0, 32'hC, B);
        tick();
        check("pre_rst.InReady", 64'(u[0].ir), 64'(0));
        drive(0, 0, 0, 0, 0);
        #2 Reset = 0;
        #1;
        check("rst.OutValid", 64'(u[0].ov), 64'(0));
        check("rst.InReady", 64'(u[0].ir), 64'(1));
        check("rst.IDInst", 64'(u[0].inst), 64'(0));
        check("rst.StallCount", 64'(u[0].sc), 64'(0));
        tick();
        Reset = 1;
        drive(1, 0, 0, 32'h10, C);
        tick();
        check("post_rst.first_push", {u[0].ov, u[0].inst}, {1'b1, C});

        // Flush to empty, then continuous push+pop on DEPTH=3.
        drive(0, 1, 0, 0, 0);
        tick();
        for (int j = 0; j < 20; j++) begin
            drive(1, 0, 1, 32'(j * 4 + 4), 32'hA0000000 + 32'(j));
            tick();
            check($sformatf("stream%0d", j), {u[1].ov, u[1].ir, u[1].pc, u[1].inst},
                  {1'b1, 1'b1, 32'(j * 4 + 4), 32'hA0000000 + 32'(j)});
        end

        // Saturation: 20 stalled edges, 4-bit counter on DEPTH=1, 16-bit on DEPTH=2.
        drive(0, 0, 0, 0, 0);
        Reset = 0;
        tick();
        Reset = 1;
        drive(1, 0, 0, 32'h20, 32'h12345678);
        repeat (21) tick();
        check("sat.cnt4", 64'(u[2].sc), 64'(15));
        check("sat.cnt16", 64'(u[0].sc), 64'(20));
        check("sat.d1_inready", 64'(u[2].ir), 64'(0));

        // Randomized traffic against the reference models.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  $urandom, $urandom);
            tick();
        end

        drive(0, 0, 0, 0, 0);
        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
